// File: rtl/sbox_byte_sequencer.sv
`ifndef SBOX_D
`define SBOX_D 0
`endif

module sbox_byte_sequencer #(
  parameter int d   = `SBOX_D,
  parameter int LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*(8+d)-1:0]   state_in,
  output logic [8+d-1:0]        sbox_in,
  output logic                  sbox_in_valid,
  input  logic [8+d-1:0]        sbox_out,
  output logic [16*(8+d)-1:0]   state_out,
  output logic                  busy,
  output logic                  done
);

  localparam int W = 8 + d;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [16*W-1:0]   src_buf;
  logic [3:0]        issue_cnt;
  logic [4:0]        cap_cnt;
  logic [LAT-1:0]    vld_dly;
  logic              launch;
  logic              capture;

  assign capture = vld_dly[LAT-1];

  always_comb begin
    state_nx      = state;
    launch        = 1'b0;
    sbox_in_valid = 1'b0;
    sbox_in       = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        sbox_in_valid = 1'b1;
        sbox_in       = src_buf[int'(issue_cnt)*W +: W];
        busy          = 1'b1;
        if (issue_cnt == 4'd15) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (capture && cap_cnt == 5'd15) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          launch   = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_buf   <= '0;
      state_out <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
    end else begin
      if (launch) begin
        src_buf   <= state_in;
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else if (state == ISSUE) begin
        issue_cnt <= issue_cnt + 4'd1;
      end
      if (capture) begin
        state_out[int'(cap_cnt[3:0])*W +: W] <= sbox_out;
        cap_cnt <= cap_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_dly <= '0;
    end else begin
      vld_dly[0] <= sbox_in_valid;
      for (int unsigned i = 1; i < LAT; i++) vld_dly[i] <= vld_dly[i-1];
    end
  end

endmodule

// File: tb/tb_sbox_byte_sequencer.sv
// tb_sbox_byte_sequencer: directed bench for sbox_byte_sequencer at LAT=4, 1 and 15
// with a behavioural S-Box (in XOR 'hA5, delayed LAT cycles) per instance.

module tb_sbox_byte_sequencer;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start    [3];
    logic [16*W-1:0] sin     [3];
    logic [16*W-1:0] sout    [3];
    logic [W-1:0]   sbi      [3];
    logic [W-1:0]   sbo      [3];
    logic           sv       [3];
    logic           busy     [3];
    logic           done     [3];

    logic [W-1:0]   p0 [4];
    logic [W-1:0]   p1 [1];
    logic [W-1:0]   p2 [15];

    int nvec = 0;
    int nerr = 0;

    sbox_byte_sequencer #(.d(0), .LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .start(start[0]), .state_in(sin[0]),
        .sbox_in(sbi[0]), .sbox_in_valid(sv[0]), .sbox_out(sbo[0]),
        .state_out(sout[0]), .busy(busy[0]), .done(done[0]));

    sbox_byte_sequencer #(.d(0), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start[1]), .state_in(sin[1]),
        .sbox_in(sbi[1]), .sbox_in_valid(sv[1]), .sbox_out(sbo[1]),
        .state_out(sout[1]), .busy(busy[1]), .done(done[1]));

    sbox_byte_sequencer #(.d(0), .LAT(15)) u_lat15 (
        .clk(clk), .rst(rst), .start(start[2]), .state_in(sin[2]),
        .sbox_in(sbi[2]), .sbox_in_valid(sv[2]), .sbox_out(sbo[2]),
        .state_out(sout[2]), .busy(busy[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural S-Box pipelines
    always_ff @(posedge clk) begin
        p0[0] <= sbi[0];
        for (int j = 1; j < 4; j++) p0[j] <= p0[j-1];
        p1[0] <= sbi[1];
        p2[0] <= sbi[2];
        for (int j = 1; j < 15; j++) p2[j] <= p2[j-1];
    end
    assign sbo[0] = p0[3]  ^ 8'hA5;
    assign sbo[1] = p1[0]  ^ 8'hA5;
    assign sbo[2] = p2[14] ^ 8'hA5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] xf(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = s[i*8 +: 8] ^ 8'hA5;
        return r;
    endfunction

    function automatic logic [127:0] rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Launch a run on instance u, follow it to its done pulse (bounded) and
    // check every issued element. hold keeps start high; pulse_at injects a
    // start pulse with a different source during ISSUE.
    task automatic run(input int u, input logic [127:0] src, input bit hold,
                       input int pulse_at, output int dcyc, output int vcnt,
                       output int first_v);
        sin[u]   = src;
        start[u] = 1'b1;
        tick();
        start[u] = hold;
        dcyc = 0; vcnt = 0; first_v = 0;
        for (int n = 1; n <= 60; n++) begin
            if (sv[u]) begin
                check($sformatf("sbox_in[u%0d,n%0d]", u, n), 128'(sbi[u]),
                      128'(src[vcnt*8 +: 8]));
                vcnt++;
                if (first_v == 0) first_v = n;
            end
            if (done[u]) begin
                dcyc = n;
                break;
            end
            if (n == pulse_at) begin
                start[u] = 1'b1;
                sin[u]   = ~src;
            end else if (!hold) begin
                start[u] = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        int dc, vc, fv;
        logic [127:0] s_a, s_b, s_c;

        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start[u] = 1'b1;
            sin[u]   = '1;
        end

        // Reset held two cycles with start asserted
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_busy",  128'(busy[0]),  '0);
            check("rst_done",  128'(done[0]),  '0);
            check("rst_valid", 128'(sv[0]),    '0);
            check("rst_sout",  sout[0],        '0);
        end
        rst = 1'b0;
        for (int u = 0; u < 3; u++) start[u] = 1'b0;
        tick();
        check("post_rst_busy",  128'(busy[0]), '0);
        check("post_rst_valid", 128'(sv[0]),   '0);
        check("post_rst_sout",  sout[0],       '0);

        // Basic run, element i = i
        for (int i = 0; i < 16; i++) s_a[i*8 +: 8] = 8'(i);
        run(0, s_a, 1'b0, 0, dc, vc, fv);
        check("basic_done_cycle", 128'(dc), 128'(21));
        check("basic_valid_cnt",  128'(vc), 128'(16));
        check("basic_first_v",    128'(fv), 128'(1));
        check("basic_sout",       sout[0],  xf(s_a));
        check("basic_busy_done",  128'(busy[0]), '0);
        tick();
        check("basic_done_pulse", 128'(done[0]), '0);
        check("basic_idle_sbi",   128'(sbi[0]),  '0);
        check("basic_idle_valid", 128'(sv[0]),   '0);

        // Start pulse during ISSUE must be ignored
        s_b = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        run(0, s_b, 1'b0, 5, dc, vc, fv);
        check("ign_done_cycle", 128'(dc), 128'(21));
        check("ign_sout",       sout[0],  xf(s_b));
        for (int c = 0; c < 6; c++) begin
            tick();
            check("ign_single_done", 128'(done[0]), '0);
        end
        check("ign_sout_hold", sout[0], xf(s_b));

        // Back-to-back with start held through DONE
        run(0, s_a, 1'b1, 0, dc, vc, fv);
        check("b2b_first_done", 128'(dc), 128'(21));
        s_c = ~s_a;
        run(0, s_c, 1'b1, 0, dc, vc, fv);
        start[0] = 1'b0;
        check("b2b_gap_first_v", 128'(fv), 128'(1));
        check("b2b_second_done", 128'(dc), 128'(21));
        check("b2b_sout",        sout[0],  xf(s_c));
        tick();

        // Reset while draining
        sin[0]   = s_b;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int n = 1; n < 19; n++) tick();
        check("mid_in_drain", 128'(busy[0] && !sv[0]), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", 128'(busy[0]), '0);
        check("mid_sout", sout[0],       '0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("mid_no_done", 128'(done[0]), '0);
        end
        check("mid_no_capture", sout[0], '0);

        // Latency sweep
        s_a = rnd_state();
        run(1, s_a, 1'b0, 0, dc, vc, fv);
        check("lat1_done_cycle", 128'(dc), 128'(18));
        check("lat1_sout",       sout[1],  xf(s_a));
        s_b = rnd_state();
        run(2, s_b, 1'b0, 0, dc, vc, fv);
        check("lat15_done_cycle", 128'(dc), 128'(32));
        check("lat15_sout",       sout[2],  xf(s_b));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
